// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer: per-channel FSM state encoding
// and the default qualification window (10 ms at 100 MHz).
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_e;

  localparam int DEF_STABLE_CYCLES = 1_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch bit: 2-FF synchroniser, stability counter and FSM.
// Outputs a registered clean level plus one-cycle rise/fall pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic db_level,
  output logic db_rise,
  output logic db_fall
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             ff1;
  logic             sync;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d, rise_d, fall_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff1      <= 1'b0;
      sync     <= 1'b0;
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      db_level <= 1'b0;
      db_rise  <= 1'b0;
      db_fall  <= 1'b0;
    end else begin
      ff1      <= sw_in;
      sync     <= ff1;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      db_level <= level_d;
      db_rise  <= rise_d;
      db_fall  <= fall_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = db_level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (sync) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync) begin
          state_d = STABLE_LO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sync) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (sync) begin
          state_d = STABLE_HI;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = STABLE_LO;
    endcase
  end

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch/button conditioner: N_CH independent debounce channels.
// Define DEBOUNCE_TOGGLE_EN to add the push-on/push-off db_toggle output.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CH          = 2,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] db_level,
  output logic [N_CH-1:0] db_rise,
`ifdef DEBOUNCE_TOGGLE_EN
  output logic [N_CH-1:0] db_fall,
  output logic [N_CH-1:0] db_toggle
`else
  output logic [N_CH-1:0] db_fall
`endif
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .sw_in   (sw_in[gi]),
      .db_level(db_level[gi]),
      .db_rise (db_rise[gi]),
      .db_fall (db_fall[gi])
    );
  end

`ifdef DEBOUNCE_TOGGLE_EN
  // Flips the cycle after each accepted press.
  always_ff @(posedge clk) begin
    if (rst) db_toggle <= '0;
    else     db_toggle <= db_toggle ^ db_rise;
  end
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer (N_CH=2, STABLE_CYCLES=8): stimulus
// pushes expected pulse events; a negedge monitor pops and compares them.
module tb_switch_debouncer;

  localparam int N_CH = 2;
  localparam int SC   = 8;
  localparam int LAT  = SC + 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] sw_in;
  logic [N_CH-1:0] db_level, db_rise, db_fall;
`ifdef DEBOUNCE_TOGGLE_EN
  logic [N_CH-1:0] db_toggle;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int cyc;
    int ch;
    int rise;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  switch_debouncer #(
    .N_CH(N_CH),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_in    (sw_in),
    .db_level (db_level),
    .db_rise  (db_rise),
`ifdef DEBOUNCE_TOGGLE_EN
    .db_fall  (db_fall),
    .db_toggle(db_toggle)
`else
    .db_fall  (db_fall)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int at, input int ch, input int rise);
    ev_t e;
    e.cyc  = at;
    e.ch   = ch;
    e.rise = rise;
    exp_q.push_back(e);
  endtask

  // Monitor: every rise/fall pulse must match the next expected event.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst === 1'b0) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (db_rise[ch] === 1'b1 || db_fall[ch] === 1'b1) begin
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_pulse_ch%0d", ch), cyc, -1);
          end else begin
            e = exp_q.pop_front();
            check("ev_cycle", cyc, e.cyc);
            check("ev_channel", ch, e.ch);
            check("ev_rise", int'(db_rise[ch]), e.rise);
            check("ev_fall", int'(db_fall[ch]), 1 - e.rise);
            check("ev_level", int'(db_level[ch]), e.rise);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c;
    rst   = 1'b1;
    sw_in = '0;
    step(3);
    check("reset_level", int'(db_level), 0);
    check("reset_rise", int'(db_rise), 0);
    check("reset_fall", int'(db_fall), 0);
`ifdef DEBOUNCE_TOGGLE_EN
    check("reset_toggle", int'(db_toggle), 0);
`endif
    rst = 1'b0;
    step(2);

    // Clean press on ch0.
    c = cyc;
    sw_in[0] = 1'b1;
    expect_ev(c + LAT, 0, 1);
    step(LAT - 1);
    check("press_level_early", int'(db_level[0]), 0);
    step(1);
    check("press_level", int'(db_level[0]), 1);
    check("press_rise", int'(db_rise[0]), 1);
    step(1);
    check("press_rise_clear", int'(db_rise[0]), 0);
    check("press_level_hold", int'(db_level[0]), 1);

    // Release on ch0.
    c = cyc;
    sw_in[0] = 1'b0;
    expect_ev(c + LAT, 0, 0);
    step(LAT - 1);
    check("release_level_early", int'(db_level[0]), 1);
    step(1);
    check("release_level", int'(db_level[0]), 0);
    check("release_fall", int'(db_fall[0]), 1);
    step(1);
    check("release_fall_clear", int'(db_fall[0]), 0);

    // Bounce: 5 high, 2 low, then held high.
    sw_in[0] = 1'b1;
    step(5);
    sw_in[0] = 1'b0;
    step(2);
    c = cyc;
    sw_in[0] = 1'b1;
    expect_ev(c + LAT, 0, 1);
    step(LAT - 1);
    check("bounce_level_early", int'(db_level[0]), 0);
    step(1);
    check("bounce_level", int'(db_level[0]), 1);
    c = cyc;
    sw_in[0] = 1'b0;
    expect_ev(c + LAT, 0, 0);
    step(LAT + 1);

    // Reset mid-qualification on ch1 (counter at 5 after 8 edges).
    c = cyc;
    sw_in[1] = 1'b1;
    step(8);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrst_level", int'(db_level), 0);
    check("midrst_rise", int'(db_rise), 0);
    check("midrst_fall", int'(db_fall), 0);
    c = cyc;
    expect_ev(c + LAT, 1, 1);
    step(LAT - 1);
    check("midrst_requal_early", int'(db_level[1]), 0);
    step(1);
    check("midrst_requal", int'(db_level[1]), 1);
    c = cyc;
    sw_in[1] = 1'b0;
    expect_ev(c + LAT, 1, 0);
    step(LAT + 1);

    // Independence: both rise together, ch1 glitches low for one cycle.
    c = cyc;
    sw_in = 2'b11;
    expect_ev(c + LAT, 0, 1);
    expect_ev(c + 5 + LAT, 1, 1);
    step(4);
    sw_in[1] = 1'b0;
    step(1);
    sw_in[1] = 1'b1;
    step(6);
    check("indep_level_ch0_only", int'(db_level), 1);
    step(5);
    check("indep_level_both", int'(db_level), 3);
    c = cyc;
    sw_in = 2'b00;
    expect_ev(c + LAT, 0, 0);
    expect_ev(c + LAT, 1, 0);
    step(LAT + 1);
    check("indep_release_level", int'(db_level), 0);

`ifdef DEBOUNCE_TOGGLE_EN
    // Three presses on ch0: toggle goes 1,0,1, one cycle after each rise.
    for (int i = 0; i < 3; i++) begin
      int prev;
      prev = (i % 2);
      c = cyc;
      sw_in[0] = 1'b1;
      expect_ev(c + LAT, 0, 1);
      step(LAT);
      check("toggle_at_rise", int'(db_toggle[0]), prev);
      step(1);
      check("toggle_after_rise", int'(db_toggle[0]), 1 - prev);
      check("toggle_ch1_idle", int'(db_toggle[1]), 0);
      c = cyc;
      sw_in[0] = 1'b0;
      expect_ev(c + LAT, 0, 0);
      step(LAT + 1);
    end
`endif

    step(3);
    check("pending_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Multi-channel conditioner for raw board slide switches and buttons; sits directly upstream of the switch-driven logic (e.g. the XOR LED path).
- Each channel passes through a 2-FF synchroniser, then a per-channel stability FSM. It emits a clean level plus one-cycle rise/fall pulses.
- A bounce or glitch shorter than the qualification window never reaches downstream logic.

Parameters:
- N_CH, 2, number of independent switch channels (>=1).
- STABLE_CYCLES, 1_000_000, consecutive clocks the synchronised input must hold a new value before it is accepted (10 ms at 100 MHz); must be >=2.
- CNT_W, $clog2(STABLE_CYCLES), counter width; derived, not overridden.

Ports:
- clk  input  1  system clock (board 100 MHz).
- rst  input  1  synchronous, active-high reset.
- sw_in  input  N_CH  raw asynchronous switch inputs.
- db_level  output  N_CH  debounced level per channel.
- db_rise  output  N_CH  one-cycle pulse when db_level goes 0->1.
- db_fall  output  N_CH  one-cycle pulse when db_level goes 1->0.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst). All state is sampled at posedge clk.
- Reset: sync FFs = 0, every FSM = STABLE_LO, counters = 0, db_level/db_rise/db_fall = 0. Reset mid-qualification discards progress; an input still held high re-qualifies the full window after rst drops.
- Synchroniser: sync = ff2 <= ff1 <= sw_in. This adds 2 cycles of latency.
- FSM per channel: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO: if sync=1, go to WAIT_HI and set cnt=0.
  - WAIT_HI:
    - If sync=0, return to STABLE_LO (glitch rejected, no pulse).
    - Else if cnt==STABLE_CYCLES-1, go to STABLE_HI, set db_level=1, pulse db_rise for 1 cycle.
    - Else cnt++.
  - STABLE_HI and WAIT_LO: mirror image with sync=0; db_fall pulses on entry to STABLE_LO.
- Latency: with sw_in steady high from edge 1, db_level and db_rise assert after edge STABLE_CYCLES+3. Falling transitions have the same latency.
- db_level, db_rise and db_fall are registered, with no combinational path from sw_in. db_rise and db_fall are never both high on one channel, and neither is high for two consecutive cycles.
- Counter never wraps: it is cleared on every WAIT entry and bounded at STABLE_CYCLES-1.
- Channels are fully independent; simultaneous transitions on multiple channels each qualify separately.

Optional Feature:
- Macro: DEBOUNCE_TOGGLE_EN.
- Defined: adds output port db_toggle (N_CH, reset 0). Each bit inverts in the cycle after its db_rise pulse, giving push-on/push-off button behaviour.
- Undefined: the port and its flops do not exist; all other behaviour is identical.

Decomposition:
- Shared package debounce_pkg holds the FSM state encoding (2-bit localparams STABLE_LO=0, WAIT_HI=1, STABLE_HI=2, WAIT_LO=3) and the default STABLE_CYCLES constant.
- Sub-module debounce_channel covers one bit: synchroniser, counter, FSM and pulse outputs.
- switch_debouncer instantiates N_CH copies in a generate loop, plus the optional toggle flops.

Test Plan (STABLE_CYCLES=8, N_CH=2):
- Clean press: sw_in[0] 0->1 held -> db_level[0]=1 and db_rise[0]=1 after edge 11 only; db_rise[0]=0 on edge 12.
- Bounce: sw_in[0] high 5 cycles, low 2, then held high -> no pulse during bounce; db_rise[0] fires once, 11 edges after the final rising sample.
- Release: from stable high, sw_in[0] held low -> db_fall[0] pulses once after 11 edges; db_level[0]=0.
- Reset mid-wait: rst for 1 cycle at cnt=5 with sw_in[1] still high -> all outputs 0; db_rise[1] fires 11 edges after rst deasserts.
- Independence: both channels rise on the same edge, ch1 glitches low once -> ch0 rises on schedule, ch1 delayed per restart.
- DEBOUNCE_TOGGLE_EN: three clean presses on ch0 -> db_toggle[0] sequence 1,0,1, each change one cycle after its db_rise.
